// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back controller.
//   WB_AW      : default write-back address width, max(1, clog2(REG_NUM))
//   wb_req_t   : one buffered write-back request {addr, data}
//   wb_src_e   : arbitration source, used to remember the last grant
package wb_pkg;

  localparam int unsigned REG_NUM    = 2;
  localparam int unsigned REG_SIZE   = 2;
  localparam int unsigned FIFO_DEPTH = 2;

  // Address width never drops to zero, even for a single-register file.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned WB_AW = addr_width(REG_NUM);

  typedef struct packed {
    logic [WB_AW-1:0]    addr;
    logic [REG_SIZE-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Write-back buffer: a small circular FIFO of {addr, data} entries.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : enqueue request (ignored while full)
//   pop                 : dequeue head (ignored while empty)
//   head                : head entry, forced to zero while empty
//   full, empty         : occupancy flags
//   tap_valid, tap_addr : per-entry valid bit and address, for hazard compare
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned AddrW = 1,
  parameter int unsigned DataW = 2,
  localparam int unsigned Width = AddrW + DataW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [Width-1:0]            push_data,
  input  logic                        pop,
  output logic [Width-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [Depth-1:0]            tap_valid,
  output logic [Depth-1:0][AddrW-1:0] tap_addr
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q          <= rd_ptr_q + PtrW'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed through valid bits or
  // the zero-gated head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head      = empty ? '0 : mem_q[rd_ptr_q];
  assign tap_valid = valid_q;

  always_comb begin
    tap_addr = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      tap_addr[i] = mem_q[i][Width-1 -: AddrW];
    end
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Merges ALU and load write-back requests into the single register-file write
// port through a small buffer, and flags operand hazards on buffered writes.
// Ports:
//   clk, rst_n                              : clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_reg/alu_data    : ALU write-back handshake
//   mem_valid/mem_ready/mem_reg/mem_data    : load write-back handshake
//   wb_hold                                 : stalls draining of the write port
//   write_reg/reg_write/write_data          : register_file write port
//   query1/query2, hazard1/hazard2          : operand hazard lookup
//   fifo_full/fifo_empty                    : buffer occupancy
module regfile_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned regNum     = REG_NUM,
  parameter int unsigned regSize    = REG_SIZE,
  parameter int unsigned FIFO_DEPTH = wb_pkg::FIFO_DEPTH,
  localparam int unsigned AW        = addr_width(regNum)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [AW-1:0]      alu_reg,
  input  logic [regSize-1:0] alu_data,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [AW-1:0]      mem_reg,
  input  logic [regSize-1:0] mem_data,
  input  logic               wb_hold,
  output logic [AW-1:0]      write_reg,
  output logic               reg_write,
  output logic [regSize-1:0] write_data,
  input  logic [AW-1:0]      query1,
  input  logic [AW-1:0]      query2,
  output logic               hazard1,
  output logic               hazard2,
  output logic               fifo_full,
  output logic               fifo_empty
);

  localparam int unsigned Width = AW + regSize;

  wb_src_e                          last_grant_q;
  logic                             grant_mem;
  logic                             grant_alu;
  logic                             can_accept;
  logic                             push;
  logic [Width-1:0]                 push_data;
  logic [Width-1:0]                 head;
  logic [FIFO_DEPTH-1:0]            tap_valid;
  logic [FIFO_DEPTH-1:0][AW-1:0]    tap_addr;

  // Round-robin: the load path wins a tie unless it won the previous one.
  assign grant_mem = mem_valid & (~alu_valid | (last_grant_q == SRC_ALU));
  assign grant_alu = alu_valid & ~grant_mem;

  // A full buffer refuses everything, even when a pop is happening this cycle.
  // Readies are also forced low while reset is asserted.
  assign can_accept = rst_n & ~fifo_full;
  assign alu_ready  = grant_alu & can_accept;
  assign mem_ready  = grant_mem & can_accept;
  assign push       = alu_ready | mem_ready;
  assign push_data  = mem_ready ? {mem_reg, mem_data} : {alu_reg, alu_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_ALU;
    end else if (push) begin
      last_grant_q <= mem_ready ? SRC_MEM : SRC_ALU;
    end
  end

  wb_fifo #(
    .Depth (FIFO_DEPTH),
    .AddrW (AW),
    .DataW (regSize)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (reg_write),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .tap_valid (tap_valid),
    .tap_addr  (tap_addr)
  );

  // The register file captures on the same edge that pops the head.
  assign reg_write  = ~fifo_empty & ~wb_hold;
  assign write_reg  = head[Width-1 -: AW];
  assign write_data = head[regSize-1:0];

  // Entries pushed this cycle are not yet valid, so they raise no hazard;
  // the entry being popped is still valid and does.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (tap_valid[i] && (tap_addr[i] == query1)) hazard1 = 1'b1;
      if (tap_valid[i] && (tap_addr[i] == query2)) hazard2 = 1'b1;
    end
  end

endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
- Initiator side of the register-file write port: merges write-back requests from the ALU and the memory-load path into the single write port (write_reg / reg_write / write_data).
- Sits between the execute/memory stages and register_file.
- Buffers requests in a small FIFO so the write port can be held off.
- Reports per-operand hazards so the operand-read stage can stall until any pending write to that register has drained.

Parameters:
- regNum, 2, number of architectural registers; address width AW = max(1, clog2(regNum)).
- regSize, 2, register data width in bits.
- FIFO_DEPTH, 2, write-back buffer entries (power of two, at least 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU write-back request valid.
- alu_ready  output  1  ALU request accepted this cycle (when alu_valid is also high).
- alu_reg  input  AW  ALU destination register.
- alu_data  input  regSize  ALU result.
- mem_valid  input  1  load write-back request valid.
- mem_ready  output  1  load request accepted this cycle.
- mem_reg  input  AW  load destination register.
- mem_data  input  regSize  load data.
- wb_hold  input  1  freezes draining of the write port.
- write_reg  output  AW  to register_file write address.
- reg_write  output  1  to register_file write enable.
- write_data  output  regSize  to register_file write data.
- query1  input  AW  read-port-1 register being fetched.
- query2  input  AW  read-port-2 register being fetched.
- hazard1  output  1  a buffered write targets query1.
- hazard2  output  1  a buffered write targets query2.
- fifo_full  output  1  buffer full.
- fifo_empty  output  1  buffer empty.

Behaviour:
- Reset: asynchronous, active-low. Clears FIFO pointers and count, and all entry valid bits. Sets last_grant to ALU, so memory has priority on the first contention.
  - During reset: reg_write=0, alu_ready=0, mem_ready=0, hazard1=0, hazard2=0, fifo_empty=1, fifo_full=0, write_reg=0, write_data=0.
- Acceptance: at most one request is enqueued per cycle.
  - Grant is round-robin between the two sources.
  - If only one source is valid, it is granted.
  - If both are valid, the source not granted last time wins.
  - ready is high only for the granted source, and only when count < FIFO_DEPTH. A full FIFO refuses both, even if a pop happens in the same cycle.
  - A handshake (valid & ready) writes {reg, data} at the tail on the rising edge. last_grant updates only on a handshake.
  - A refused source must hold valid, reg and data stable until it is accepted.
- Drain: the head entry drives write_reg and write_data combinationally from registered storage.
  - reg_write = !fifo_empty & !wb_hold.
  - A pop happens on each edge where reg_write=1, so register_file captures the value on that same edge.
  - Latency with an empty FIFO and wb_hold=0: handshake at edge N, reg_write high during cycle N..N+1, register updated at edge N+1.
  - When empty: write_reg=0 and write_data=0.
- Simultaneous push and pop: both happen; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Ordering: writes leave in acceptance order. Two buffered writes to the same register are applied in order, so the last accepted one wins.
- Hazards: hazard1 is high if any valid FIFO entry has reg == query1; hazard2 likewise for query2. Both are combinational.
  - An entry being popped this cycle still asserts its hazard.
  - An entry accepted this cycle does not assert a hazard until the next cycle.
- wb_hold: only stops draining. Acceptance continues until the FIFO is full.
- Reset mid-operation: all buffered writes are discarded. No partial write is issued.

Decomposition:
- Shared package wb_pkg:
  - localparam WB_AW computed from regNum.
  - typedef wb_req_t {reg addr, data}.
  - enum wb_src_e {SRC_ALU, SRC_MEM} for last_grant.
- Sub-module wb_fifo:
  - Parameterised FIFO with push, pop, head, full, empty and per-entry valid/addr taps.
  - The taps feed the hazard compare.
- Arbitration and hazard compare stay in the top module.

Test Plan:
- ALU-only write: ALU request reg=1, data=2'b10, wb_hold=0 → alu_ready=1 in that cycle; next cycle reg_write=1, write_reg=1, write_data=2'b10; fifo_empty=1 after the following edge.
- Contention after reset: alu_valid and mem_valid both high (ALU reg 0 / 2'b01, MEM reg 1 / 2'b11) → MEM granted first, ALU granted next cycle; write order is MEM then ALU.
- Full FIFO: wb_hold=1 and three back-to-back ALU requests → first two accepted, fifo_full=1, third sees alu_ready=0; release wb_hold → two writes in order, then the third is accepted.
- Hazard: while holding an entry for reg 1, query1=1 and query2=0 → hazard1=1, hazard2=0; after the pop, hazard1=0.
- Same-register ordering: ALU writes reg 0 = 2'b01, then MEM writes reg 0 = 2'b10 → two reg_write pulses in that order, final register value 2'b10.
- Reset mid-operation: two entries buffered under wb_hold, then rst_n pulsed low → reg_write=0 immediately, fifo_empty=1, hazards clear, no write issued after release.
